// File: rtl/qam_bit_mapper_interp.sv
// Serial bit stream -> Gray-mapped square-QAM I/Q levels, zero-stuffed by OSR for an RRC interpolator.
// Optional build macro DIFF_QUAD_EN: differential encoding of the per-axis sign bits.
module qam_bit_mapper_interp #(
    parameter int BITS_PER_SYM = 4,
    parameter int OSR          = 16,
    parameter int SAMPLE_W     = 5
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic signed [SAMPLE_W-1:0] sam_i,
    output logic signed [SAMPLE_W-1:0] sam_q,
    output logic                       sam_valid,
    input  logic                       sam_ready,
    output logic                       sym_strobe,
    output logic                       underrun
);

    localparam int M     = BITS_PER_SYM / 2;
    localparam int CNT_W = $clog2(BITS_PER_SYM + 1);
    localparam int PH_W  = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS_PER_SYM);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    // Gray-coded axis bits (MSB first) -> odd amplitude level 2n-(2^M-1).
    function automatic logic signed [SAMPLE_W-1:0] gray_to_level(input logic [M-1:0] g);
        logic [M-1:0] n;
        int           lvl;
        n[M-1] = g[M-1];
        for (int k = M - 2; k >= 0; k--) n[k] = n[k+1] ^ g[k];
        lvl = 2 * int'(n) - ((1 << M) - 1);
        return lvl[SAMPLE_W-1:0];
    endfunction

    logic [BITS_PER_SYM-1:0]    coll_p0;
    logic [CNT_W-1:0]           cnt_p0;
    logic [BITS_PER_SYM-1:0]    tx_bits_p0;
    logic [M-1:0]               gi_p0;
    logic [M-1:0]               gq_p0;
    logic signed [SAMPLE_W-1:0] map_i_p0;
    logic signed [SAMPLE_W-1:0] map_q_p0;
    logic                       full_p0;
    logic                       accept;
    logic                       pf_wr;
    logic                       load_act;

    logic signed [SAMPLE_W-1:0] pf_i_p1;
    logic signed [SAMPLE_W-1:0] pf_q_p1;
    logic                       vld_p1;

    logic signed [SAMPLE_W-1:0] act_i_p2;
    logic signed [SAMPLE_W-1:0] act_q_p2;
    logic [PH_W-1:0]            phase_p2;
    logic [PH_W-1:0]            phase_nxt;
    state_t                     state;
    state_t                     state_nxt;
    logic                       und_r;
    logic                       und_nxt;

    assign full_p0   = (cnt_p0 == CNT_FULL);
    assign bit_ready = !(full_p0 && vld_p1);
    assign accept    = bit_valid && bit_ready;
    assign pf_wr     = full_p0 && (!vld_p1 || load_act);
    assign underrun  = und_r;

    // ---- stage p0: bit collection and symbol mapping ----
`ifdef DIFF_QUAD_EN
    logic prev_si;
    logic prev_sq;

    always_comb begin
        tx_bits_p0    = coll_p0;
        tx_bits_p0[0] = coll_p0[0] ^ prev_si;
        tx_bits_p0[M] = coll_p0[M] ^ prev_sq;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_si <= 1'b0;
            prev_sq <= 1'b0;
        end else if (pf_wr) begin
            prev_si <= tx_bits_p0[0];
            prev_sq <= tx_bits_p0[M];
        end
    end
`else
    assign tx_bits_p0 = coll_p0;
`endif

    always_comb begin
        gi_p0 = '0;
        gq_p0 = '0;
        for (int j = 0; j < M; j++) begin
            gi_p0[M-1-j] = tx_bits_p0[j];
            gq_p0[M-1-j] = tx_bits_p0[M+j];
        end
    end

    assign map_i_p0 = gray_to_level(gi_p0);
    assign map_q_p0 = gray_to_level(gq_p0);

    // A full register hands off and may take the first bit of the next symbol in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            coll_p0 <= '0;
            cnt_p0  <= '0;
        end else if (pf_wr) begin
            coll_p0 <= accept ? BITS_PER_SYM'(bit_in) : '0;
            cnt_p0  <= accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            coll_p0 <= coll_p0 | (BITS_PER_SYM'(bit_in) << cnt_p0);
            cnt_p0  <= cnt_p0 + CNT_W'(1);
        end
    end

    // ---- stage p1: one-symbol prefetch buffer ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pf_i_p1 <= '0;
            pf_q_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (pf_wr) begin
            pf_i_p1 <= map_i_p0;
            pf_q_p1 <= map_q_p0;
            vld_p1  <= 1'b1;
        end else if (load_act) begin
            vld_p1  <= 1'b0;
        end
    end

    // ---- stage p2: active symbol and zero-stuffing FSM ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            phase_p2 <= '0;
            und_r    <= 1'b0;
            act_i_p2 <= '0;
            act_q_p2 <= '0;
        end else begin
            state    <= state_nxt;
            phase_p2 <= phase_nxt;
            und_r    <= und_nxt;
            if (load_act) begin
                act_i_p2 <= pf_i_p1;
                act_q_p2 <= pf_q_p1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_p2;
        load_act   = 1'b0;
        und_nxt    = 1'b0;
        sam_valid  = 1'b0;
        sym_strobe = 1'b0;
        sam_i      = '0;
        sam_q      = '0;
        case (state)
            IDLE: begin
                if (vld_p1) begin
                    load_act  = 1'b1;
                    phase_nxt = '0;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                sam_valid = 1'b1;
                if (phase_p2 == '0) begin
                    sym_strobe = 1'b1;
                    sam_i      = act_i_p2;
                    sam_q      = act_q_p2;
                end
                if (sam_ready) begin
                    if (phase_p2 == PH_LAST) begin
                        phase_nxt = '0;
                        if (vld_p1) begin
                            load_act = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            und_nxt   = 1'b1;
                        end
                    end else begin
                        phase_nxt = phase_p2 + PH_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_qam_bit_mapper_interp.sv
// Directed bench for qam_bit_mapper_interp: 16-QAM and QPSK instances, OSR=4.
module tb_qam_bit_mapper_interp;

`ifdef DIFF_QUAD_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b1;

    logic              b4_in = 1'b0, b4_vld = 1'b0, b4_rdy;
    logic signed [4:0] s4_i, s4_q;
    logic              s4_vld, s4_rdy = 1'b1, s4_stb, s4_und;

    logic              b2_in = 1'b0, b2_vld = 1'b0, b2_rdy;
    logic signed [3:0] s2_i, s2_q;
    logic              s2_vld, s2_rdy = 1'b1, s2_stb, s2_und;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    qam_bit_mapper_interp #(.BITS_PER_SYM(4), .OSR(4), .SAMPLE_W(5)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .bit_in(b4_in), .bit_valid(b4_vld), .bit_ready(b4_rdy),
        .sam_i(s4_i), .sam_q(s4_q), .sam_valid(s4_vld), .sam_ready(s4_rdy),
        .sym_strobe(s4_stb), .underrun(s4_und)
    );

    qam_bit_mapper_interp #(.BITS_PER_SYM(2), .OSR(4), .SAMPLE_W(4)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .bit_in(b2_in), .bit_valid(b2_vld), .bit_ready(b2_rdy),
        .sam_i(s2_i), .sam_q(s2_q), .sam_valid(s2_vld), .sam_ready(s2_rdy),
        .sym_strobe(s2_stb), .underrun(s2_und)
    );

    task automatic pulse_reset();
        b4_vld = 1'b0; b4_in = 1'b0; s4_rdy = 1'b1;
        b2_vld = 1'b0; b2_in = 1'b0; s2_rdy = 1'b1;
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        total += 8;
        if (s4_vld !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", s4_vld); end
        if (s4_i !== 5'sd0 || s4_q !== 5'sd0) begin bad++; $display("FAIL reset_iq got=%0d,%0d exp=0,0", s4_i, s4_q); end
        if (s4_stb !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", s4_stb); end
        if (s4_und !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", s4_und); end
        if (b4_rdy !== 1'b1) begin bad++; $display("FAIL reset_bit_ready got=%b exp=1", b4_rdy); end
        if (s2_vld !== 1'b0) begin bad++; $display("FAIL reset_valid2 got=%b exp=0", s2_vld); end
        if (s2_i !== 4'sd0 || s2_q !== 4'sd0) begin bad++; $display("FAIL reset_iq2 got=%0d,%0d exp=0,0", s2_i, s2_q); end
        if (b2_rdy !== 1'b1) begin bad++; $display("FAIL reset_bit_ready2 got=%b exp=1", b2_rdy); end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_symbol();
        logic [3:0] pat;
        pat = 4'b1100;  // b0..b3 = 0,0,1,1
        pulse_reset();
        for (int n = 0; n < 12; n++) begin
            int  ei, eq;
            bit  ev, es, eu;
            ev = (n >= 6 && n <= 9);
            es = (n == 6);
            ei = es ? -3 : 0;
            eq = es ? 1 : 0;
            eu = (n == 10);
            total += 5;
            if (s4_vld !== ev) begin bad++; $display("FAIL single_valid n=%0d got=%b exp=%b", n, s4_vld, ev); end
            if (s4_stb !== es) begin bad++; $display("FAIL single_strobe n=%0d got=%b exp=%b", n, s4_stb, es); end
            if (s4_i !== 5'(ei)) begin bad++; $display("FAIL single_i n=%0d got=%0d exp=%0d", n, s4_i, ei); end
            if (s4_q !== 5'(eq)) begin bad++; $display("FAIL single_q n=%0d got=%0d exp=%0d", n, s4_q, eq); end
            if (s4_und !== eu) begin bad++; $display("FAIL single_underrun n=%0d got=%b exp=%b", n, s4_und, eu); end
            b4_vld = (n < 4);
            b4_in  = (n < 4) ? pat[n] : 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic test_continuous();
        logic [3:0] pat;
        pat = 4'b0110;  // b0..b3 = 0,1,1,0
        pulse_reset();
        for (int n = 0; n < 24; n++) begin
            int  ei, eq, k;
            bit  ev, es, eu;
            ev = (n >= 6 && n <= 21);
            es = ev && ((n - 6) % 4 == 0);
            k  = (n - 6) / 4;
            ei = es ? -1 : 0;
            eq = es ? ((DIFF && (k % 2 == 1)) ? -3 : 3) : 0;
            eu = (n == 22);
            total += 6;
            if (s4_vld !== ev) begin bad++; $display("FAIL cont_valid n=%0d got=%b exp=%b", n, s4_vld, ev); end
            if (s4_stb !== es) begin bad++; $display("FAIL cont_strobe n=%0d got=%b exp=%b", n, s4_stb, es); end
            if (s4_i !== 5'(ei)) begin bad++; $display("FAIL cont_i n=%0d got=%0d exp=%0d", n, s4_i, ei); end
            if (s4_q !== 5'(eq)) begin bad++; $display("FAIL cont_q n=%0d got=%0d exp=%0d", n, s4_q, eq); end
            if (s4_und !== eu) begin bad++; $display("FAIL cont_underrun n=%0d got=%b exp=%b", n, s4_und, eu); end
            if (b4_rdy !== 1'b1) begin bad++; $display("FAIL cont_bit_ready n=%0d got=%b exp=1", n, b4_rdy); end
            b4_vld = (n < 16);
            b4_in  = (n < 16) ? pat[n % 4] : 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [3:0] pat;
        int         bidx;
        pat  = 4'b1100;  // b0..b3 = 0,0,1,1
        bidx = 0;
        pulse_reset();
        for (int n = 0; n < 24; n++) begin
            int  ei, eq, k;
            bit  ev, es, eu, er;
            ev = (n >= 6 && n <= 21);
            es = (n >= 6 && n <= 10) || n == 14 || n == 18;
            k  = (n <= 10) ? 0 : ((n == 14) ? 1 : 2);
            ei = es ? -3 : 0;
            eq = es ? ((DIFF && k == 1) ? -1 : 1) : 0;
            eu = (n == 22);
            er = !(n == 12 || n == 13);
            total += 6;
            if (s4_vld !== ev) begin bad++; $display("FAIL bp_valid n=%0d got=%b exp=%b", n, s4_vld, ev); end
            if (s4_stb !== es) begin bad++; $display("FAIL bp_strobe n=%0d got=%b exp=%b", n, s4_stb, es); end
            if (s4_i !== 5'(ei)) begin bad++; $display("FAIL bp_i n=%0d got=%0d exp=%0d", n, s4_i, ei); end
            if (s4_q !== 5'(eq)) begin bad++; $display("FAIL bp_q n=%0d got=%0d exp=%0d", n, s4_q, eq); end
            if (s4_und !== eu) begin bad++; $display("FAIL bp_underrun n=%0d got=%b exp=%b", n, s4_und, eu); end
            if (b4_rdy !== er) begin bad++; $display("FAIL bp_bit_ready n=%0d got=%b exp=%b", n, b4_rdy, er); end
            s4_rdy = !(n >= 5 && n <= 9);
            b4_vld = (bidx < 12);
            b4_in  = pat[bidx % 4];
            if (b4_vld && b4_rdy) bidx++;
            @(negedge CLK);
        end
        s4_rdy = 1'b1;
    endtask

    task automatic test_qpsk();
        logic [1:0] pats [2];
        int         exi  [2];
        int         exq  [2];
        pats[0] = 2'b01; exi[0] = 1;  exq[0] = -1;  // bits 1,0
        pats[1] = 2'b10; exi[1] = -1; exq[1] = 1;   // bits 0,1
        for (int c = 0; c < 2; c++) begin
            pulse_reset();
            for (int n = 0; n < 10; n++) begin
                int  ei, eq;
                bit  ev, es, eu;
                ev = (n >= 4 && n <= 7);
                es = (n == 4);
                ei = es ? exi[c] : 0;
                eq = es ? exq[c] : 0;
                eu = (n == 8);
                total += 5;
                if (s2_vld !== ev) begin bad++; $display("FAIL qpsk_valid c=%0d n=%0d got=%b exp=%b", c, n, s2_vld, ev); end
                if (s2_stb !== es) begin bad++; $display("FAIL qpsk_strobe c=%0d n=%0d got=%b exp=%b", c, n, s2_stb, es); end
                if (s2_i !== 4'(ei)) begin bad++; $display("FAIL qpsk_i c=%0d n=%0d got=%0d exp=%0d", c, n, s2_i, ei); end
                if (s2_q !== 4'(eq)) begin bad++; $display("FAIL qpsk_q c=%0d n=%0d got=%0d exp=%0d", c, n, s2_q, eq); end
                if (s2_und !== eu) begin bad++; $display("FAIL qpsk_underrun c=%0d n=%0d got=%b exp=%b", c, n, s2_und, eu); end
                b2_vld = (n < 2);
                b2_in  = (n < 2) ? pats[c][n] : 1'b0;
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_diff_quad();
        pulse_reset();
        for (int n = 0; n < 14; n++) begin
            int  ei, eq;
            bit  ev, es, eu;
            ev = (n >= 4 && n <= 11);
            es = (n == 4 || n == 8);
            ei = !es ? 0 : ((n == 8 && DIFF) ? -1 : 1);
            eq = ei;
            eu = (n == 12);
            total += 5;
            if (s2_vld !== ev) begin bad++; $display("FAIL diff_valid n=%0d got=%b exp=%b", n, s2_vld, ev); end
            if (s2_stb !== es) begin bad++; $display("FAIL diff_strobe n=%0d got=%b exp=%b", n, s2_stb, es); end
            if (s2_i !== 4'(ei)) begin bad++; $display("FAIL diff_i n=%0d got=%0d exp=%0d", n, s2_i, ei); end
            if (s2_q !== 4'(eq)) begin bad++; $display("FAIL diff_q n=%0d got=%0d exp=%0d", n, s2_q, eq); end
            if (s2_und !== eu) begin bad++; $display("FAIL diff_underrun n=%0d got=%b exp=%b", n, s2_und, eu); end
            b2_vld = (n < 4);
            b2_in  = (n < 4);
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid_symbol();
        logic [5:0] pre;
        logic [3:0] pat;
        pre = 6'b111100;  // 0,0,1,1 then partial 1,1
        pat = 4'b0110;    // fresh symbol 0,1,1,0
        pulse_reset();
        for (int n = 0; n < 6; n++) begin
            b4_vld = 1'b1;
            b4_in  = pre[n];
            @(negedge CLK);
        end
        b4_vld = 1'b0;
        total += 2;
        if (s4_vld !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_valid got=%b exp=1", s4_vld); end
        if (s4_i !== -5'sd3) begin bad++; $display("FAIL rst_mid_pre_i got=%0d exp=-3", s4_i); end
        RST_N = 1'b0;
        #1;
        total += 5;
        if (s4_vld !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", s4_vld); end
        if (s4_i !== 5'sd0 || s4_q !== 5'sd0) begin bad++; $display("FAIL rst_mid_iq got=%0d,%0d exp=0,0", s4_i, s4_q); end
        if (s4_stb !== 1'b0) begin bad++; $display("FAIL rst_mid_strobe got=%b exp=0", s4_stb); end
        if (s4_und !== 1'b0) begin bad++; $display("FAIL rst_mid_underrun got=%b exp=0", s4_und); end
        if (b4_rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_bit_ready got=%b exp=1", b4_rdy); end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int n = 0; n < 12; n++) begin
            int  ei, eq;
            bit  ev, es, eu;
            ev = (n >= 6 && n <= 9);
            es = (n == 6);
            ei = es ? -1 : 0;
            eq = es ? 3 : 0;
            eu = (n == 10);
            total += 5;
            if (s4_vld !== ev) begin bad++; $display("FAIL rst_fresh_valid n=%0d got=%b exp=%b", n, s4_vld, ev); end
            if (s4_stb !== es) begin bad++; $display("FAIL rst_fresh_strobe n=%0d got=%b exp=%b", n, s4_stb, es); end
            if (s4_i !== 5'(ei)) begin bad++; $display("FAIL rst_fresh_i n=%0d got=%0d exp=%0d", n, s4_i, ei); end
            if (s4_q !== 5'(eq)) begin bad++; $display("FAIL rst_fresh_q n=%0d got=%0d exp=%0d", n, s4_q, eq); end
            if (s4_und !== eu) begin bad++; $display("FAIL rst_fresh_underrun n=%0d got=%b exp=%b", n, s4_und, eu); end
            b4_vld = (n < 4);
            b4_in  = (n < 4) ? pat[n] : 1'b0;
            @(negedge CLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_symbol();
        test_continuous();
        test_back_to_back_backpressure();
        test_qpsk();
        test_diff_quad();
        test_reset_mid_symbol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
